chu_multi_blinker: RTL and testbench

//  N-channel LED blinker core for one FPro MMIO slot; successor to the 4-LED blink core.
//  Per-channel programmable half-period, per-channel mode (off/on/blink/burst), and counted bursts.

---
 rtl/chu_multi_blinker.sv | 103 ++++++++++
 tb/tb_chu_multi_blinker.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/chu_multi_blinker.sv
// chu_multi_blinker: N-channel LED blinker slot with per-channel half-period, mode and counted bursts
module chu_multi_blinker #(
    parameter int N_CH     = 4,
    parameter int PERIOD_W = 16,
    parameter int TICK_DIV = 100_000,
    parameter int DEF_HALF = 500
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            cs,
    input  logic            read,
    input  logic            write,
    input  logic [4:0]      addr,
    input  logic [31:0]     wr_data,
    output logic [31:0]     rd_data,
    output logic [N_CH-1:0] dout
);
    localparam int PW = $clog2(TICK_DIV);
    logic [PW-1:0] presc_q, presc_d;
    logic [2*N_CH-1:0] mode_q, mode_d;
    logic [7:0] count_q, count_d;
    logic [N_CH-1:0] busy;
    logic [N_CH-1:0][PERIOD_W-1:0] half;
    logic wr, tick, unused_ok;

    assign wr = cs & write;
    assign tick = presc_q == PW'(TICK_DIV - 1);
    assign presc_d = tick ? '0 : presc_q + 1'b1;
    assign mode_d = (wr && addr == 5'd16) ? wr_data[2*N_CH-1:0] : mode_q;
    assign count_d = (wr && addr == 5'd18) ? wr_data[7:0] : count_q;
    assign unused_ok = &{1'b0, read, wr_data};

    // free-running tick prescaler and the slot-wide mode and burst-count registers
    always_ff @(posedge clk) begin
        if (reset) begin
            presc_q <= '0;
            mode_q  <= '0;
            count_q <= '0;
        end else begin
            presc_q <= presc_d;
            mode_q  <= mode_d;
            count_q <= count_d;
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic [PERIOD_W-1:0] half_q, half_d, cnt_q, cnt_d, hm1;
        logic [7:0] rem_q, rem_d;
        logic [1:0] m_q, m_d;
        logic led_q, led_d, busy_q, busy_d, dout_q, dout_d;
        logic hit, clr, start, run, wrap, fall;

        assign m_q = mode_q[2*i+:2];
        assign m_d = mode_d[2*i+:2];
        assign hit = wr && addr == 5'(i);
        // a half-period write or a change of this channel's mode restarts it from a dark LED
        assign clr = hit || m_d != m_q;
        assign start = wr && addr == 5'd17 && wr_data[i] && m_q == 2'b11 && count_q != '0;
        assign run = m_q == 2'b10 || (m_q == 2'b11 && busy_q);
        assign hm1 = (half_q == '0) ? '0 : half_q - 1'b1;
        assign wrap = tick && run && cnt_q == hm1;
        assign fall = wrap && led_q && m_q == 2'b11;
        assign half_d = hit ? wr_data[PERIOD_W-1:0] : half_q;
        assign cnt_d = (clr || start) ? '0 : (tick && run) ? (wrap ? '0 : cnt_q + 1'b1) : cnt_q;
        assign led_d = (clr || start) ? 1'b0 : wrap ? ~led_q : led_q;
        assign rem_d = start ? count_q : fall ? rem_q - 1'b1 : rem_q;
        assign busy_d = clr ? 1'b0 : start ? 1'b1 : (fall && rem_q == 8'd1) ? 1'b0 : busy_q;
        assign dout_d = (m_d == 2'b01) ? 1'b1 : m_d[1] ? led_d : 1'b0;
        assign half[i] = half_q;
        assign busy[i] = busy_q;
        assign dout[i] = dout_q;

        // per-channel half-period, tick counter, LED toggle and burst bookkeeping
        always_ff @(posedge clk) begin
            if (reset) begin
                half_q <= PERIOD_W'(DEF_HALF);
                cnt_q  <= '0;
                rem_q  <= '0;
                led_q  <= 1'b0;
                busy_q <= 1'b0;
                dout_q <= 1'b0;
            end else begin
                half_q <= half_d;
                cnt_q  <= cnt_d;
                rem_q  <= rem_d;
                led_q  <= led_d;
                busy_q <= busy_d;
                dout_q <= dout_d;
            end
        end
    end

    // register read mux, combinational on addr
    always_comb begin
        rd_data = '0;
        for (int k = 0; k < N_CH; k++)
            if (addr == 5'(k)) rd_data = 32'(half[k]);
        if (addr == 5'd16) rd_data = 32'(mode_q);
        else if (addr == 5'd17) rd_data = 32'(busy);
        else if (addr == 5'd18) rd_data = 32'(count_q);
        else if (addr == 5'd19) rd_data = 32'(dout);
    end
endmodule

// File: tb/tb_chu_multi_blinker.sv
// tb_chu_multi_blinker: directed register-table and multi-cycle blink/burst checks
module tb_chu_multi_blinker;
    logic clk = 1'b0, reset = 1'b1, cs = 1'b0, read = 1'b0, write = 1'b0;
    logic [4:0] addr = 5'd17;
    logic [31:0] wr_data = '0;
    logic [31:0] rd_data;
    logic [3:0] dout;
    int n_cmp = 0, n_err = 0, since_rst = 0;

    typedef struct {
        logic        w;
        logic [4:0]  a;
        logic [31:0] d;
        logic [31:0] e;
    } vec_t;
    vec_t vt [15];

    chu_multi_blinker #(.N_CH(4), .PERIOD_W(16), .TICK_DIV(4), .DEF_HALF(500)) dut (
        .clk(clk), .reset(reset), .cs(cs), .read(read), .write(write),
        .addr(addr), .wr_data(wr_data), .rd_data(rd_data), .dout(dout)
    );

    always #5 clk = ~clk;

    // cycles since the last reset edge; tick edges are the multiples of 4
    always @(posedge clk) since_rst <= reset ? 0 : since_rst + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        cs = 1'b1; write = 1'b1; addr = a; wr_data = d;
        @(negedge clk);
        cs = 1'b0; write = 1'b0; addr = 5'd17;
    endtask

    // write landing on a tick edge
    task automatic wr_al(input logic [4:0] a, input logic [31:0] d);
        do @(negedge clk); while (since_rst % 4 != 3);
        cs = 1'b1; write = 1'b1; addr = a; wr_data = d;
        @(negedge clk);
        cs = 1'b0; write = 1'b0; addr = 5'd17;
    endtask

    // channel 1 burst of p pulses, started on the tick edge just before n=0; optional count=1 write at n=wr_at
    task automatic burst_run(input int p, input int cyc, input int wr_at);
        for (int n = 0; n <= cyc; n++) begin
            if (n > 0) @(negedge clk);
            cs = (n == wr_at); write = (n == wr_at);
            addr = (n == wr_at) ? 5'd18 : 5'd17;
            wr_data = 32'd1;
            #1;
            chk($sformatf("burst p=%0d dout n=%0d", p, n), 32'(dout),
                (n < 8 * p && n % 8 >= 4) ? 32'd2 : 32'd0);
            if (n != wr_at)
                chk($sformatf("burst p=%0d busy n=%0d", p, n), rd_data, (n < 8 * p) ? 32'd2 : 32'd0);
        end
        cs = 1'b0; write = 1'b0; addr = 5'd17;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vt[0]  = '{1'b0, 5'd0,  32'd0,          32'd500};
        vt[1]  = '{1'b0, 5'd16, 32'd0,          32'd0};
        vt[2]  = '{1'b0, 5'd17, 32'd0,          32'd0};
        vt[3]  = '{1'b0, 5'd18, 32'd0,          32'd0};
        vt[4]  = '{1'b0, 5'd19, 32'd0,          32'd0};
        vt[5]  = '{1'b0, 5'd20, 32'd0,          32'd0};
        vt[6]  = '{1'b1, 5'd1,  32'd7,          32'd7};
        vt[7]  = '{1'b1, 5'd3,  32'h0001_2345,  32'h2345};
        vt[8]  = '{1'b1, 5'd18, 32'h0000_01ff,  32'hff};
        vt[9]  = '{1'b1, 5'd16, 32'hffff_ff00,  32'h0};
        vt[10] = '{1'b1, 5'd17, 32'h0000_000f,  32'h0};
        vt[11] = '{1'b1, 5'd21, 32'd5,          32'h0};
        vt[12] = '{1'b0, 5'd31, 32'd0,          32'h0};
        vt[13] = '{1'b0, 5'd2,  32'd0,          32'd500};
        vt[14] = '{1'b1, 5'd0,  32'd0,          32'd0};

        repeat (3) @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 15; k++) begin
            if (vt[k].w) wr(vt[k].a, vt[k].d);
            addr = vt[k].a;
            #1;
            chk($sformatf("vec%0d rd", k), rd_data, vt[k].e);
            chk($sformatf("vec%0d dout", k), 32'(dout), 32'd0);
        end
        addr = 5'd17;

        // blink: half0=2, mode write on a tick edge; rise 8 clk later, then toggles every 8
        do_reset();
        wr(5'd0, 32'd2);
        wr_al(5'd16, 32'h2);
        for (int n = 0; n <= 24; n++) begin
            if (n > 0) @(negedge clk);
            #1;
            chk($sformatf("blink n=%0d", n), 32'(dout), 32'((n / 8) % 2));
        end

        // half write on the terminal tick beats the toggle and restarts the count
        do_reset();
        wr(5'd0, 32'd2);
        wr_al(5'd16, 32'h2);
        for (int n = 0; n <= 6; n++) begin
            if (n > 0) @(negedge clk);
            #1;
            chk($sformatf("pre-hw n=%0d", n), 32'(dout), 32'd0);
        end
        wr_al(5'd0, 32'd2);
        for (int n = 0; n <= 9; n++) begin
            if (n > 0) @(negedge clk);
            #1;
            chk($sformatf("hw n=%0d", n), 32'(dout), (n >= 8) ? 32'd1 : 32'd0);
        end
        wr(5'd0, 32'd2);
        #1;
        chk("hw forces dark", 32'(dout), 32'd0);

        // burst: three 4-clk pulses on channel 1
        do_reset();
        wr(5'd1, 32'd1);
        wr(5'd18, 32'd3);
        wr(5'd16, 32'hC);
        wr_al(5'd17, 32'h2);
        burst_run(3, 32, -1);

        // restart after one pulse, count change mid-burst ignored by the running burst
        wr_al(5'd17, 32'h2);
        burst_run(3, 10, -1);
        wr_al(5'd17, 32'h2);
        burst_run(3, 30, 2);
        wr_al(5'd17, 32'h2);
        burst_run(1, 12, -1);
        wr(5'd18, 32'd0);
        wr_al(5'd17, 32'h2);
        burst_run(0, 16, -1);

        // mode on for channel 3: one cycle of latency
        @(negedge clk);
        cs = 1'b1; write = 1'b1; addr = 5'd16; wr_data = 32'h40;
        #1;
        chk("on pre-edge dout", 32'(dout), 32'd0);
        @(negedge clk);
        cs = 1'b0; write = 1'b0; addr = 5'd19;
        #1;
        chk("on dout", 32'(dout), 32'h8);
        chk("rd19 live dout", rd_data, 32'h8);
        addr = 5'd20;
        #1;
        chk("rd20 unmapped", rd_data, 32'h0);
        addr = 5'd16;
        #1;
        chk("rd16 mode", rd_data, 32'h40);

        // reset in the middle of a burst
        wr(5'd16, 32'hC);
        wr(5'd18, 32'd3);
        wr_al(5'd17, 32'h2);
        burst_run(3, 5, -1);
        do_reset();
        #1;
        chk("rst dout", 32'(dout), 32'd0);
        addr = 5'd17;
        #1;
        chk("rst busy", rd_data, 32'd0);
        addr = 5'd18;
        #1;
        chk("rst count", rd_data, 32'd0);
        addr = 5'd1;
        #1;
        chk("rst half1", rd_data, 32'd500);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
